spi_slave: RTL and testbench
============================

// Module: spi_slave
// PURPOSE
//  SPI mode-0 slave (CPOL=0, CPHA=0), MSB first, one word per DATA_WIDTH SCLK cycles.
//  Counterpart of the SPI master on the FPGA link: it receives bytes on MOSI and
//  returns the preloaded reply on MISO. The whole block runs on the system clock; the
//  SPI inputs are oversampled, synchronised and edge-detected. No SCLK-domain logic.
// PARAMETERS
//  DATA_WIDTH   8  bits per SPI word.
//  SYNC_STAGES  2  synchroniser flops on cs/sclk/mosi, range 0..3.
//                  0 = master on the same clk; combinational pass-through.
// PORTS
//  clk       in   1           system clock, rising edge.
//  reset     in   1           asynchronous, active-high; clears all state.
//  data_in   in   DATA_WIDTH  reply word to send on MISO; sampled as described below.
//  data_out  out  DATA_WIDTH  last complete word received on MOSI.
//  done      out  1           one-clk pulse: data_out has just been updated.
//  buzy      out  1           high while a transfer is in progress (state SHIFT).
//  cs        in   1           chip select, active low.
//  sclk      in   1           serial clock from the master, idle low.
//  mosi      in   1           master-out/slave-in.
//  miso      out  1           slave-out/master-in; registered; 0 when not selected.
// BEHAVIOUR
//  Reset: state=IDLE, data_out=0, done=0, buzy=0, miso=0, bit counter=0.
//  Reset also clears the shift registers, the sync flops and the edge-detect history.
//  Sync: cs, sclk and mosi each pass through SYNC_STAGES flops, the same for all three.
//  rise/fall = registered-vs-current compare on synced sclk. cs_fall/cs_rise likewise.
//  SCLK high/low phases must each last >= SYNC_STAGES+1 clk; shorter phases are unsupported.
//  FSM:
//   IDLE:  every clk, miso_reg<=data_in[MSB]; tx_sh<={data_in[MSB-1:0],1'b0}.
//          cnt=0. miso pin driven 0. On cs_fall -> SHIFT; the preloaded MSB appears on miso.
//   SHIFT: miso pin = miso_reg.
//          On rise: rx_sh<={rx_sh[MSB-1:0],mosi_s}; cnt<=cnt+1, wrapping at DATA_WIDTH.
//           - On the rise that completes the word (cnt==DATA_WIDTH-1):
//             data_out<={rx_sh[MSB-1:0],mosi_s}; done<=1 for exactly one clk; cnt<=0.
//          On fall with cnt!=0: miso_reg<=tx_sh[MSB]; tx_sh<=tx_sh<<1.
//          On fall with cnt==0 (start of the next word in a burst):
//           - miso_reg<=data_in[MSB]; tx_sh<={data_in[MSB-1:0],0}, so a new reply loads.
//          On cs_rise, which has priority over any same-cycle sclk edge: -> IDLE.
//           - A partial word is discarded: no done, data_out unchanged, cnt<=0.
//  buzy=(state==SHIFT). done is never high in IDLE except in the cycle of the final rise.
//  done latency: 1 clk after the synced final rising edge (SYNC_STAGES+1 clk after the pin).
//  Burst: multiple words under one cs-low are allowed; done pulses once per word.
//  Leaving reset with cs already low: stay IDLE until cs is seen high then low.
//   There is no transfer from a mid-frame reset release.
//  Unsupported: sclk edges while cs is high are ignored; mosi is not sampled then.
// TESTING
//  1 Single byte: data_in=8'hA5; master sends 8'h3C -> data_out=8'h3C;
//    done one clk; miso bits 1,0,1,0,0,1,0,1.
//  2 Burst: data_in=8'h81 then 8'h7E changed after the 1st done; master sends 8'h55,8'hAA.
//    -> done x2, data_out 55 then AA, master receives 81,7E.
//  3 Abort: cs rises after 5 bits of 8'hFF.
//    -> no done, data_out holds old value, buzy falls, next full byte 8'h12 received intact.
//  4 Reset mid-transfer: assert reset after 3 bits with cs still low.
//    -> all outputs 0 at once; IDLE until cs high->low; the next byte 8'hC3 is correct.
//  5 Edge cases: bytes 8'h00 and 8'hFF back-to-back with data_in=8'hFF/8'h00.
//    -> exact echo; no bit slip across the word boundary.
//  6 SYNC_STAGES=0 vs 2 with the codebase master (sclk=clk/2 and clk/8 respectively).
//    -> 16 random bytes are loop-checked both ways.

Source files
------------

// File: rtl/spi_slave.sv
// -----------------------------------------------------------------------------
// spi_slave
//   SPI mode-0 slave (CPOL=0, CPHA=0), MSB first, DATA_WIDTH bits per word.
//   Everything runs on the system clock. cs/sclk/mosi are oversampled through
//   SYNC_STAGES flops and edge-detected; there is no logic clocked by sclk.
//   The reply word is taken from data_in while idle and again at the start
//   of every further word in a burst. It is shifted out on miso, which is
//   registered.
//
// Parameters
//   DATA_WIDTH   bits per SPI word (>= 3)
//   SYNC_STAGES  synchroniser depth on cs/sclk/mosi, 0..3 (0 = pass-through)
//
// Ports
//   clk       in   system clock, rising edge
//   reset     in   asynchronous, active-high; clears all state
//   data_in   in   reply word to send on miso
//   data_out  out  last complete word received on mosi
//   done      out  one-clk pulse when data_out has just been updated
//   buzy      out  high while a transfer is in progress
//   cs        in   chip select, active low
//   sclk      in   serial clock from the master, idle low
//   mosi      in   master-out/slave-in
//   miso      out  slave-out/master-in, 0 when not selected
// -----------------------------------------------------------------------------
module spi_slave #(
  parameter int DATA_WIDTH  = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  done,
  output logic                  buzy,
  input  logic                  cs,
  input  logic                  sclk,
  input  logic                  mosi,
  output logic                  miso
);

  localparam int MSB = DATA_WIDTH - 1;
  localparam int CW  = $clog2(DATA_WIDTH);

  localparam logic [CW-1:0] CNT_ZERO = CW'(0);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DATA_WIDTH - 1);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  // Reply preload: the first bit goes straight to the miso register and the
  // rest waits in the transmit shifter with a zero fill at the bottom.
  function automatic logic [DATA_WIDTH-1:0] tx_preload(input logic [DATA_WIDTH-1:0] word);
    tx_preload = {word[MSB-1:0], 1'b0};
  endfunction

  // ---------------------------------------------------------------------------
  // Input synchronisers (same depth for all three so mosi stays aligned with
  // the sclk edge that samples it)
  // ---------------------------------------------------------------------------
  logic cs_s;
  logic sclk_s;
  logic mosi_s;

  generate
    if (SYNC_STAGES == 0) begin : g_nosync
      assign cs_s   = cs;
      assign sclk_s = sclk;
      assign mosi_s = mosi;
    end else begin : g_sync
      logic [SYNC_STAGES-1:0] cs_sync_q;
      logic [SYNC_STAGES-1:0] sclk_sync_q;
      logic [SYNC_STAGES-1:0] mosi_sync_q;

      // Synchroniser shift chains; reset low so a cs held low through reset
      // release never looks like a falling edge.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          cs_sync_q   <= '0;
          sclk_sync_q <= '0;
          mosi_sync_q <= '0;
        end else begin
          cs_sync_q[0]   <= cs;
          sclk_sync_q[0] <= sclk;
          mosi_sync_q[0] <= mosi;
          for (int i = 1; i < SYNC_STAGES; i++) begin
            cs_sync_q[i]   <= cs_sync_q[i-1];
            sclk_sync_q[i] <= sclk_sync_q[i-1];
            mosi_sync_q[i] <= mosi_sync_q[i-1];
          end
        end
      end

      assign cs_s   = cs_sync_q[SYNC_STAGES-1];
      assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
      assign mosi_s = mosi_sync_q[SYNC_STAGES-1];
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Edge detection on the synchronised cs and sclk
  // ---------------------------------------------------------------------------
  logic sclk_prev_q;
  logic cs_prev_q;
  logic sclk_rise;
  logic sclk_fall;
  logic cs_rise;
  logic cs_fall;

  // Edge-detect history; cleared so reset never manufactures an edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sclk_prev_q <= 1'b0;
      cs_prev_q   <= 1'b0;
    end else begin
      sclk_prev_q <= sclk_s;
      cs_prev_q   <= cs_s;
    end
  end

  assign sclk_rise = sclk_s & ~sclk_prev_q;
  assign sclk_fall = ~sclk_s & sclk_prev_q;
  assign cs_rise   = cs_s & ~cs_prev_q;
  assign cs_fall   = ~cs_s & cs_prev_q;

  // ---------------------------------------------------------------------------
  // Transfer FSM and datapath
  // ---------------------------------------------------------------------------
  state_t                state_q,  state_d;
  logic [CW-1:0]         cnt_q,    cnt_d;
  logic [DATA_WIDTH-2:0] rx_q,     rx_d;    // top bit is never needed: the
                                            // completed word is formed directly
  logic [DATA_WIDTH-1:0] tx_q,     tx_d;
  logic                  mreg_q,   mreg_d;
  logic [DATA_WIDTH-1:0] dout_q,   dout_d;
  logic                  done_q,   done_d;
  logic                  busy_q,   busy_d;
  logic                  miso_q,   miso_d;

  // Next-state and datapath decode for the IDLE/SHIFT transfer machine.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rx_d    = rx_q;
    tx_d    = tx_q;
    mreg_d  = mreg_q;
    dout_d  = dout_q;
    done_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // Keep tracking data_in so the reply is current whenever cs drops.
        mreg_d = data_in[MSB];
        tx_d   = tx_preload(data_in);
        cnt_d  = CNT_ZERO;
        if (cs_fall) begin
          state_d = ST_SHIFT;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_SHIFT: begin
        if (cs_rise) begin
          // Deselect wins over any same-cycle sclk edge; a partial word is
          // dropped without touching data_out.
          state_d = ST_IDLE;
          cnt_d   = CNT_ZERO;
        end else if (sclk_rise) begin
          rx_d = {rx_q[DATA_WIDTH-3:0], mosi_s};
          if (cnt_q == CNT_LAST) begin
            dout_d = {rx_q, mosi_s};
            done_d = 1'b1;
            cnt_d  = CNT_ZERO;
          end else begin
            cnt_d  = cnt_q + CNT_ONE;
          end
        end else if (sclk_fall) begin
          if (cnt_q != CNT_ZERO) begin
            mreg_d = tx_q[MSB];
            tx_d   = {tx_q[MSB-1:0], 1'b0};
          end else begin
            // Falling edge after a completed word: start the next reply.
            mreg_d = data_in[MSB];
            tx_d   = tx_preload(data_in);
          end
        end else begin
          state_d = ST_SHIFT;
        end
      end

      default: begin
        state_d = ST_IDLE;
        cnt_d   = CNT_ZERO;
      end
    endcase

    // Outputs are registered from the next state so buzy and miso switch on
    // the same edge as the state itself.
    busy_d = (state_d == ST_SHIFT);
    if (state_d == ST_SHIFT) begin
      miso_d = mreg_d;
    end else begin
      miso_d = 1'b0;
    end
  end

  // State, datapath and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= CNT_ZERO;
      rx_q    <= '0;
      tx_q    <= '0;
      mreg_q  <= 1'b0;
      dout_q  <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      miso_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rx_q    <= rx_d;
      tx_q    <= tx_d;
      mreg_q  <= mreg_d;
      dout_q  <= dout_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      miso_q  <= miso_d;
    end
  end

  assign data_out = dout_q;
  assign done     = done_q;
  assign buzy     = busy_q;
  assign miso     = miso_q;

endmodule

// File: tb/tb_spi_slave.sv
// -----------------------------------------------------------------------------
// tb_spi_slave
//   Two slaves share one set of pins: u_dut0 (SYNC_STAGES=0, latency 1 clk)
//   and u_dut2 (SYNC_STAGES=2, latency 3 clk). A bench master drives mode-0
//   frames on the falling clk edge. Every master action that has a visible
//   effect (select, deselect, completed word) is logged with its cycle. The
//   model replays the log after each slave's own latency, giving the expected
//   data_out / done / buzy / miso for every cycle.
// -----------------------------------------------------------------------------
module tb_spi_slave;

  localparam int EV_BUSY = 0;
  localparam int EV_WORD = 1;
  localparam int M_FULL  = 0;
  localparam int M_ABORT = 1;
  localparam int M_RESET = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] data_in = 8'h00;
  logic       cs = 1'b1;
  logic       sclk = 1'b0;
  logic       mosi = 1'b0;

  logic [7:0] dout0, dout2;
  logic       done0, done2, busy0, busy2, miso0, miso2;

  always #5 clk = ~clk;

  spi_slave #(.DATA_WIDTH(8), .SYNC_STAGES(0)) u_dut0 (
    .clk(clk), .reset(reset), .data_in(data_in), .data_out(dout0), .done(done0),
    .buzy(busy0), .cs(cs), .sclk(sclk), .mosi(mosi), .miso(miso0)
  );

  spi_slave #(.DATA_WIDTH(8), .SYNC_STAGES(2)) u_dut2 (
    .clk(clk), .reset(reset), .data_in(data_in), .data_out(dout2), .done(done2),
    .buzy(busy2), .cs(cs), .sclk(sclk), .mosi(mosi), .miso(miso2)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int n_done0 = 0;

  // Master-side event log: cycle of the pin action, kind, value.
  int         ev_cyc [$];
  int         ev_kind[$];
  logic [7:0] ev_val [$];

  // Model state per slave (index 0: SYNC 0, index 1: SYNC 2).
  int         lat    [2] = '{1, 3};
  int         ptr    [2] = '{0, 0};
  logic [7:0] exp_do [2] = '{8'h00, 8'h00};
  logic       exp_bsy[2] = '{1'b0, 1'b0};
  bit         chk_en [2] = '{1'b1, 1'b1};

  logic [7:0] tx_w [16];
  logic [7:0] rp_w [16];

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic push_ev(input int kind, input logic [7:0] v);
    ev_cyc.push_back(cyc);
    ev_kind.push_back(kind);
    ev_val.push_back(v);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) if (done0 === 1'b1) n_done0 <= n_done0 + 1;

  // Per-cycle compare of both slaves against the replayed event log.
  always @(negedge clk) begin
    logic       e_done;
    logic [7:0] a_do;
    logic       a_done, a_busy, a_miso;
    int         sid;
    for (int k = 0; k < 2; k++) begin
      e_done = 1'b0;
      if (reset) begin
        exp_do[k]  = 8'h00;
        exp_bsy[k] = 1'b0;
        ptr[k]     = ev_cyc.size();
      end else begin
        while (ptr[k] < ev_cyc.size() && ev_cyc[ptr[k]] + lat[k] <= cyc) begin
          if (ev_kind[ptr[k]] == EV_WORD) begin
            exp_do[k] = ev_val[ptr[k]];
            e_done    = 1'b1;
          end else begin
            exp_bsy[k] = ev_val[ptr[k]][0];
          end
          ptr[k]++;
        end
      end
      sid    = (k == 0) ? 0 : 2;
      a_do   = (k == 0) ? dout0 : dout2;
      a_done = (k == 0) ? done0 : done2;
      a_busy = (k == 0) ? busy0 : busy2;
      a_miso = (k == 0) ? miso0 : miso2;
      if (chk_en[k]) begin
        check8($sformatf("s%0d_data_out", sid), a_do, exp_do[k]);
        check8($sformatf("s%0d_done", sid), {7'd0, a_done}, {7'd0, e_done});
        check8($sformatf("s%0d_buzy", sid), {7'd0, a_busy}, {7'd0, exp_bsy[k]});
        if (!exp_bsy[k]) check8($sformatf("s%0d_miso_idle", sid), {7'd0, a_miso}, 8'h00);
      end
    end
  end

  // One cs-low frame of n words with half-period hph clks. mode M_ABORT raises
  // cs after nbits bits; M_RESET leaves cs low after nbits bits.
  task automatic xfer(input int n, input int hph, input int mode, input int nbits);
    logic [7:0] r0, r2;
    int  bits;
    bit  stop;
    bits = 0;
    stop = 1'b0;
    data_in = rp_w[0];
    @(negedge clk);
    cs   = 1'b0;
    mosi = tx_w[0][7];
    push_ev(EV_BUSY, 8'h01);
    repeat (hph) @(negedge clk);
    for (int w = 0; w < n && !stop; w++) begin
      r0 = 8'h00;
      r2 = 8'h00;
      for (int b = 0; b < 8 && !stop; b++) begin
        r0 = {r0[6:0], miso0};
        r2 = {r2[6:0], miso2};
        sclk = 1'b1;
        bits++;
        if (b == 7) push_ev(EV_WORD, tx_w[w]);
        repeat (hph - 1) @(negedge clk);
        if (b == 7 && w + 1 < n) data_in = rp_w[w+1];
        @(negedge clk);
        sclk = 1'b0;
        if (b < 7) mosi = tx_w[w][6-b];
        else if (w + 1 < n) mosi = tx_w[w+1][7];
        else mosi = 1'b0;
        repeat (hph) @(negedge clk);
        if (mode != M_FULL && bits == nbits) stop = 1'b1;
      end
      if (!stop) begin
        check8("rx_s0", r0, rp_w[w]);
        if (chk_en[1]) check8("rx_s2", r2, rp_w[w]);
      end
    end
    if (mode != M_RESET) begin
      cs   = 1'b1;
      mosi = 1'b0;
      push_ev(EV_BUSY, 8'h00);
      repeat (2 * hph + 4) @(negedge clk);
    end
  endtask

  initial begin
    int nd;
    #1;
    check8("rst_data_out0", dout0, 8'h00);
    check8("rst_data_out2", dout2, 8'h00);
    check8("rst_outs0", {5'd0, done0, busy0, miso0}, 8'h00);
    check8("rst_outs2", {5'd0, done2, busy2, miso2}, 8'h00);
    repeat (3) @(negedge clk);
    #2 reset = 1'b0;
    repeat (6) @(negedge clk);

    // Single byte: reply A5 must come out as 1,0,1,0,0,1,0,1.
    tx_w[0] = 8'h3C; rp_w[0] = 8'hA5;
    nd = n_done0;
    xfer(1, 4, M_FULL, 0);
    check8("t1_data_out0", dout0, 8'h3C);
    check8("t1_data_out2", dout2, 8'h3C);
    check8("t1_done_count", 8'(n_done0 - nd), 8'd1);

    // Burst with the reply changed after the first done.
    tx_w[0] = 8'h55; tx_w[1] = 8'hAA; rp_w[0] = 8'h81; rp_w[1] = 8'h7E;
    nd = n_done0;
    xfer(2, 4, M_FULL, 0);
    check8("t2_data_out0", dout0, 8'hAA);
    check8("t2_done_count", 8'(n_done0 - nd), 8'd2);

    // Abort after 5 bits of FF, then a clean byte.
    tx_w[0] = 8'hFF; rp_w[0] = 8'h00;
    nd = n_done0;
    xfer(1, 4, M_ABORT, 5);
    check8("t3_held0", dout0, 8'hAA);
    check8("t3_held2", dout2, 8'hAA);
    check8("t3_no_done", 8'(n_done0 - nd), 8'd0);
    check8("t3_buzy", {6'd0, busy0, busy2}, 8'h00);
    tx_w[0] = 8'h12; rp_w[0] = 8'h5A;
    xfer(1, 4, M_FULL, 0);
    check8("t3_next0", dout0, 8'h12);

    // Reset after 3 bits with cs still low.
    tx_w[0] = 8'hF0; rp_w[0] = 8'hC0;
    xfer(1, 4, M_RESET, 3);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check8("t4_rst_data_out0", dout0, 8'h00);
    check8("t4_rst_data_out2", dout2, 8'h00);
    check8("t4_rst_outs", {2'd0, done0, busy0, miso0, done2, busy2, miso2}, 8'h00);
    repeat (3) @(negedge clk);
    #2 reset = 1'b0;
    repeat (12) @(negedge clk);
    check8("t4_stay_idle", {6'd0, busy0, busy2}, 8'h00);
    cs = 1'b1;
    repeat (8) @(negedge clk);
    tx_w[0] = 8'hC3; rp_w[0] = 8'h3C;
    xfer(1, 4, M_FULL, 0);
    check8("t4_next0", dout0, 8'hC3);
    check8("t4_next2", dout2, 8'hC3);

    // All-zero / all-one words back to back.
    tx_w[0] = 8'h00; tx_w[1] = 8'hFF; rp_w[0] = 8'hFF; rp_w[1] = 8'h00;
    xfer(2, 4, M_FULL, 0);
    check8("t5_data_out0", dout0, 8'hFF);

    // 16 random words at sclk = clk/8, both slaves.
    for (int i = 0; i < 16; i++) begin
      tx_w[i] = 8'($urandom_range(255));
      rp_w[i] = 8'($urandom_range(255));
    end
    xfer(16, 4, M_FULL, 0);
    check8("t6_slow_last2", dout2, tx_w[15]);

    // 16 random words at sclk = clk/2: only the unsynchronised slave applies.
    chk_en[1] = 1'b0;
    for (int i = 0; i < 16; i++) begin
      tx_w[i] = 8'($urandom_range(255));
      rp_w[i] = 8'($urandom_range(255));
    end
    xfer(16, 1, M_FULL, 0);
    check8("t6_fast_last0", dout0, tx_w[15]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
